// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: single-stage registered bitwise logic unit with a
// valid/ready handshake on both sides.
//
// Optional feature: define LOGIC_UNIT_STATS_EN to add the 16-bit op_count
// port, which counts accepted input transfers and wraps at 16'hFFFF.
//
// Output register FSM:
//   state | meaning
//   EMPTY | no result held, out_valid=0, in_ready=1
//   FULL  | result held in y/zero/parity, out_valid=1, in_ready=out_ready
//
// OPW is fixed at 3; the opcode decode below assumes a 3-bit op.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [15:0]      op_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [OPW-1:0] OP_AND  = OPW'(0);
  localparam logic [OPW-1:0] OP_OR   = OPW'(1);
  localparam logic [OPW-1:0] OP_NOTA = OPW'(2);
  localparam logic [OPW-1:0] OP_NAND = OPW'(3);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
  localparam logic [OPW-1:0] OP_XNOR = OPW'(6);
  localparam logic [OPW-1:0] OP_PASS = OPW'(7);

  state_t           state;
  logic [WIDTH-1:0] result;
  logic             take_in;
  logic             take_out;

  // The only combinational input-to-output path: the stage can accept
  // whenever it is empty or its current result is leaving this cycle.
  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign take_in   = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;

  // Bitwise operation select on the operands presented this cycle.
  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NOTA: result = ~a;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_PASS: result = b;
      default: result = '0;
    endcase
  end

  // Output register and EMPTY/FULL state; flags are derived from the new
  // result so they always describe the value being loaded into y.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      y      <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (take_in) state <= FULL;
        FULL:  if (take_out && !take_in) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (take_in) begin
        y      <= result;
        zero   <= ~|result;
        parity <= ^result;
      end
    end
  end

`ifdef LOGIC_UNIT_STATS_EN
  // Accepted-transaction counter; natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 16'd0;
    end else if (take_in) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe (WIDTH=8).
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;
`ifdef LOGIC_UNIT_STATS_EN
  logic [15:0] op_count;
`endif

  int n_cmp;
  int n_err;

  logic_unit_pipe #(.WIDTH(8), .OPW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity)
`ifdef LOGIC_UNIT_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd1; out_ready = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (y !== 8'h00) begin n_err++; $display("FAIL reset_y got=%h exp=00", y); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got=%b exp=1", zero); end
    n_cmp++; if (parity !== 1'b0) begin n_err++; $display("FAIL reset_parity got=%b exp=0", parity); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef LOGIC_UNIT_STATS_EN
    n_cmp++; if (op_count !== 16'd0) begin n_err++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
`endif
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_y [8];
    exp_y = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h3C};
    a = 8'hF0; b = 8'h3C; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      step();
      n_cmp++; if (y !== exp_y[i]) begin n_err++; $display("FAIL sweep_y op=%0d got=%h exp=%h", i, y, exp_y[i]); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sweep_valid op=%0d got=%b exp=1", i, out_valid); end
      n_cmp++; if (zero !== 1'b0 || parity !== 1'b0) begin n_err++; $display("FAIL sweep_flags op=%0d got=%b%b exp=00", i, zero, parity); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1; in_valid = 1'b1;
    a = 8'hAA; b = 8'hAA; op = 3'd5;
    step();
    n_cmp++; if ({y, zero, parity} !== {8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL flags_xor got=%h z=%b p=%b exp=00 z=1 p=0", y, zero, parity); end
    op = 3'd1;
    step();
    n_cmp++; if ({y, zero, parity} !== {8'hAA, 1'b0, 1'b0}) begin n_err++; $display("FAIL flags_or got=%h z=%b p=%b exp=AA z=0 p=0", y, zero, parity); end
    a = 8'h01; b = 8'h00; op = 3'd1;
    step();
    n_cmp++; if ({y, zero, parity} !== {8'h01, 1'b0, 1'b1}) begin n_err++; $display("FAIL flags_par got=%h z=%b p=%b exp=01 z=0 p=1", y, zero, parity); end
    op = 3'd2;
    step();
    n_cmp++; if ({y, zero, parity} !== {8'hFE, 1'b0, 1'b1}) begin n_err++; $display("FAIL flags_nota got=%h z=%b p=%b exp=FE z=0 p=1", y, zero, parity); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_ignore();
    in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h12; b = 8'h34; op = 3'd7;
    step();
    a = 8'h00; b = 8'h00; op = 3'd4;
    step();
    n_cmp++; if (y !== 8'hFE || out_valid !== 1'b0) begin n_err++; $display("FAIL ignore got y=%h v=%b exp y=FE v=0", y, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'hF0; b = 8'h3C; op = 3'd0;
    step();
    n_cmp++; if (y !== 8'h30 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_load got y=%h v=%b exp y=30 v=1", y, out_valid); end
    a = 8'hFF; b = 8'h0F; op = 3'd1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      step();
      n_cmp++; if (y !== 8'h30 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold cyc=%0d got y=%h v=%b exp y=30 v=1", i, y, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (y !== 8'hFF || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next got y=%h v=%b exp y=FF v=1", y, out_valid); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (y !== 8'hFF || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got y=%h v=%b exp y=FF v=0", y, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    out_ready = 1'b1; in_valid = 1'b1;
    b = 8'h55; op = 3'd5;
    a = 8'h00;
    step();
    for (int i = 1; i <= 10; i++) begin
      a = 8'(i);
      step();
      exp_v = 8'(i) ^ 8'h55;
      n_cmp++; if (out_valid !== 1'b1 || y !== exp_v) begin n_err++; $display("FAIL b2b idx=%0d got y=%h v=%b exp y=%h v=1", i, y, out_valid, exp_v); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || y !== 8'h5F) begin n_err++; $display("FAIL b2b_drain got y=%h v=%b exp y=5F v=0", y, out_valid); end
  endtask

  task automatic test_reset_while_full();
    out_ready = 1'b0; in_valid = 1'b1;
    a = 8'hF0; b = 8'h3C; op = 3'd0;
    step();
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL rwf_full got v=%b r=%b exp v=1 r=0", out_valid, in_ready); end
    rst = 1'b1;
    a = 8'h0F; op = 3'd1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, y, zero, parity} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin n_err++; $display("FAIL rwf_clear got v=%b y=%h z=%b p=%b exp v=0 y=00 z=1 p=0", out_valid, y, zero, parity); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rwf_in_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || y !== 8'h00) begin n_err++; $display("FAIL rwf_lost got v=%b y=%h exp v=0 y=00", out_valid, y); end
  endtask

`ifdef LOGIC_UNIT_STATS_EN
  task automatic test_stats();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; a = 8'h01; b = 8'h02; op = 3'd1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (op_count !== 16'd3) begin n_err++; $display("FAIL stats_3 got=%0d exp=3", op_count); end
    for (int i = 3; i < 65537; i++) step();
    in_valid = 1'b0;
    step();
    n_cmp++; if (op_count !== 16'd1) begin n_err++; $display("FAIL stats_wrap got=%0d exp=1", op_count); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; op = 3'd0;
    test_reset();
    test_op_sweep();
    test_flags();
    test_ignore();
    test_backpressure();
    test_back_to_back();
    test_reset_while_full();
`ifdef LOGIC_UNIT_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
